// File: rtl/program_loader.sv
// Program loader: zero-fills the program BRAM, streams an image into it,
// then releases the core from reset with a single start pulse.
module program_loader #(
    parameter int unsigned               DATA_WIDTH       = 32,
    parameter int unsigned               ADDRESS_BITS     = 32,
    parameter int unsigned               MEM_ADDRESS_BITS = 10,
    parameter logic [ADDRESS_BITS-1:0]   BOOT_ADDRESS     = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_request,
    input  logic                          load_valid,
    input  logic [DATA_WIDTH-1:0]         load_data,
    input  logic                          load_last,
    output logic                          load_ready,
    output logic                          mem_write,
    output logic [MEM_ADDRESS_BITS-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]         mem_data,
    output logic [DATA_WIDTH/8-1:0]       mem_byte_en,
    output logic                          core_reset,
    output logic                          start,
    output logic [ADDRESS_BITS-1:0]       program_address,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [MEM_ADDRESS_BITS:0]     word_count
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAIN,
        START,
        RUN
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [MEM_ADDRESS_BITS-1:0]   clear_addr;
    logic                          write_pending;
    logic [MEM_ADDRESS_BITS-1:0]   write_addr;
    logic [DATA_WIDTH-1:0]         write_data;
    logic [MEM_ADDRESS_BITS:0]     count;
    logic                          overflow_flag;
    logic                          accept;
    logic                          mem_full;
    logic                          restart;
    logic                          in_clear;

    assign accept   = (state == LOAD) && load_valid;
    assign mem_full = count[MEM_ADDRESS_BITS];
    assign restart  = ((state == IDLE) || (state == RUN)) && load_request;
    assign in_clear = (state == CLEAR);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_request) state_next = CLEAR;
            CLEAR:   if (clear_addr == '1) state_next = LOAD;
            LOAD:    if (accept && load_last) state_next = DRAIN;
            DRAIN:   state_next = START;
            START:   state_next = RUN;
            RUN:     if (load_request) state_next = CLEAR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accepted words are registered and written one cycle later; once the
    // memory is full further words are swallowed and only flag overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clear_addr    <= '0;
            write_pending <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;
            count         <= '0;
            overflow_flag <= 1'b0;
        end else begin
            write_pending <= 1'b0;
            if (in_clear) begin
                clear_addr <= clear_addr + 1'b1;
            end
            if (restart) begin
                clear_addr    <= '0;
                count         <= '0;
                overflow_flag <= 1'b0;
            end
            if (accept) begin
                if (!mem_full) begin
                    write_pending <= 1'b1;
                    write_addr    <= count[MEM_ADDRESS_BITS-1:0];
                    write_data    <= load_data;
                    count         <= count + 1'b1;
                end else begin
                    overflow_flag <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        load_ready      = (state == LOAD);
        mem_write       = in_clear || write_pending;
        mem_address     = '0;
        mem_data        = '0;
        mem_byte_en     = '0;
        if (in_clear) begin
            mem_address = clear_addr;
        end else if (write_pending) begin
            mem_address = write_addr;
            mem_data    = write_data;
        end
        if (mem_write) begin
            mem_byte_en = '1;
        end
        core_reset      = !((state == START) || (state == RUN));
        start           = (state == START);
        program_address = BOOT_ADDRESS;
        busy            = in_clear || (state == LOAD) || (state == DRAIN) || (state == START);
        done            = (state == RUN);
        overflow        = overflow_flag;
        word_count      = count;
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a 16-word program memory:
// a scenario table plus a reset-abort sequence, checked cycle by cycle.
module tb_program_loader;

    localparam int unsigned DW    = 32;
    localparam int unsigned AB    = 32;
    localparam int unsigned MAB   = 4;
    localparam int          DEPTH = 16;
    localparam logic [AB-1:0] BOOT = 32'h0000_0000;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            load_request = 1'b0;
    logic            load_valid = 1'b0;
    logic [DW-1:0]   load_data = '0;
    logic            load_last = 1'b0;
    logic            load_ready;
    logic            mem_write;
    logic [MAB-1:0]  mem_address;
    logic [DW-1:0]   mem_data;
    logic [DW/8-1:0] mem_byte_en;
    logic            core_reset;
    logic            start;
    logic [AB-1:0]   program_address;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [MAB:0]    word_count;

    program_loader #(
        .DATA_WIDTH(DW),
        .ADDRESS_BITS(AB),
        .MEM_ADDRESS_BITS(MAB),
        .BOOT_ADDRESS(BOOT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .load_request(load_request),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_last(load_last),
        .load_ready(load_ready),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_data(mem_data),
        .mem_byte_en(mem_byte_en),
        .core_reset(core_reset),
        .start(start),
        .program_address(program_address),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic            ready;
        logic            wr;
        logic [MAB-1:0]  addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
        logic            core_reset;
        logic            start;
        logic [AB-1:0]   pa;
        logic            busy;
        logic            done;
        logic            ovf;
        logic [MAB:0]    wc;
    } outs_t;

    typedef struct {
        int n;
        int gap;          // 0 valid every cycle, 1 every other cycle, 2 random
        bit fixed_image;
        bit req_in_clear;
        int exp_wc;
        bit exp_ovf;
    } scen_t;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] img[$];

    function automatic outs_t mk(input logic ready, input logic wr, input int addr,
                                 input logic [DW-1:0] data, input logic cr, input logic st,
                                 input logic bz, input logic dn, input logic ov, input int wc);
        outs_t o;
        o.ready      = ready;
        o.wr         = wr;
        o.addr       = addr[MAB-1:0];
        o.data       = data;
        o.be         = wr ? 4'hF : 4'h0;
        o.core_reset = cr;
        o.start      = st;
        o.pa         = BOOT;
        o.busy       = bz;
        o.done       = dn;
        o.ovf        = ov;
        o.wc         = wc[MAB:0];
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.ready      = load_ready;
        o.wr         = mem_write;
        o.addr       = mem_address;
        o.data       = mem_data;
        o.be         = mem_byte_en;
        o.core_reset = core_reset;
        o.start      = start;
        o.pa         = program_address;
        o.busy       = busy;
        o.done       = done;
        o.ovf        = overflow;
        o.wc         = word_count;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: the spec's rules applied per cycle -- 16 clear writes, then
    // each accepted word lands at the next address one cycle later.
    task automatic do_load(input int n, input int gap, input bit req_in_clear, input int abort_at);
        int            wq_addr[$];
        logic [DW-1:0] wq_data[$];
        int            wc = 0;
        bit            ovf = 0;
        bit            pw = 0;
        int            paddr = 0;
        logic [DW-1:0] pdata = '0;
        int            i = 0;
        int            cyc = 0;
        bit            v;
        bit            last;
        int            m;

        @(negedge clock);
        load_request = 1'b1;
        load_valid   = 1'($urandom % 2);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clock);
            check_outs("clear", mk(0, 1, k, '0, 1, 0, 1, 0, 0, 0));
            load_request = req_in_clear && (k == 3);
            load_valid   = 1'($urandom % 2);
            load_data    = $urandom;
            load_last    = 1'($urandom % 2);
        end
        load_request = 1'b0;

        forever begin
            @(negedge clock);
            check_outs("load", mk(1, pw, pw ? paddr : 0, pw ? pdata : '0, 1, 0, 1, 0, ovf, wc));
            if (mem_write) begin
                wq_addr.push_back(int'(mem_address));
                wq_data.push_back(mem_data);
            end
            if (abort_at >= 0 && i == abort_at) begin
                #2 reset = 1'b0;
                #1 check_outs("reset_abort", mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0));
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    check_outs("reset_hold", mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0));
                    load_valid = 1'($urandom % 2);
                end
                reset      = 1'b1;
                load_valid = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    check_outs("idle_after_abort", mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0));
                    load_valid = 1'($urandom % 2);
                    load_last  = 1'($urandom % 2);
                end
                load_valid = 1'b0;
                return;
            end
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = 1'($urandom % 2);
            endcase
            last       = (i == n - 1);
            load_valid = v;
            load_data  = v ? img[i] : $urandom;
            load_last  = v ? last : 1'($urandom % 2);
            if (v) begin
                if (wc < DEPTH) begin
                    pw    = 1;
                    paddr = wc;
                    pdata = img[i];
                    wc++;
                end else begin
                    pw  = 0;
                    ovf = 1;
                end
                i++;
            end else begin
                pw = 0;
            end
            cyc++;
            if (v && last) break;
            if (cyc > 2000) begin
                check_int("load_budget", cyc, 2000);
                break;
            end
        end

        @(negedge clock);
        check_outs("drain", mk(0, pw, pw ? paddr : 0, pw ? pdata : '0, 1, 0, 1, 0, ovf, wc));
        if (mem_write) begin
            wq_addr.push_back(int'(mem_address));
            wq_data.push_back(mem_data);
        end
        load_valid = 1'($urandom % 2);
        load_data  = $urandom;
        load_last  = 1'($urandom % 2);

        @(negedge clock);
        check_outs("start", mk(0, 0, 0, '0, 0, 1, 1, 0, ovf, wc));
        load_valid = 1'($urandom % 2);

        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check_outs("run", mk(0, 0, 0, '0, 0, 0, 0, 1, ovf, wc));
            load_valid = 1'($urandom % 2);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;

        m = (n < DEPTH) ? n : DEPTH;
        check_int("write_count", wq_addr.size(), m);
        for (int j = 0; j < m && j < wq_addr.size(); j++) begin
            total++;
            if (wq_addr[j] != j || wq_data[j] !== img[j]) begin
                bad++;
                $display("FAIL image_word[%0d]: actual addr=%0d data=%h required addr=%0d data=%h",
                         j, wq_addr[j], wq_data[j], j, img[j]);
            end
        end
    endtask

    task automatic build_image(input int n, input bit fixed_image);
        img.delete();
        for (int j = 0; j < n; j++) begin
            img.push_back($urandom);
        end
        if (fixed_image && n >= 3) begin
            img[0] = 32'h0000_0093;
            img[1] = 32'h0010_0113;
            img[2] = 32'h0020_81B3;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl[8];
        tbl[0] = '{n: 3,  gap: 0, fixed_image: 1, req_in_clear: 0, exp_wc: 3,  exp_ovf: 0};
        tbl[1] = '{n: 3,  gap: 1, fixed_image: 1, req_in_clear: 1, exp_wc: 3,  exp_ovf: 0};
        tbl[2] = '{n: 17, gap: 0, fixed_image: 0, req_in_clear: 0, exp_wc: 16, exp_ovf: 1};
        tbl[3] = '{n: 1,  gap: 0, fixed_image: 0, req_in_clear: 0, exp_wc: 1,  exp_ovf: 0};
        tbl[4] = '{n: 5,  gap: 2, fixed_image: 0, req_in_clear: 1, exp_wc: 5,  exp_ovf: 0};
        tbl[5] = '{n: 16, gap: 0, fixed_image: 0, req_in_clear: 0, exp_wc: 16, exp_ovf: 0};
        tbl[6] = '{n: 20, gap: 2, fixed_image: 0, req_in_clear: 0, exp_wc: 16, exp_ovf: 1};
        tbl[7] = '{n: 2,  gap: 1, fixed_image: 0, req_in_clear: 0, exp_wc: 2,  exp_ovf: 0};

        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_outs("reset", mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0));
            load_valid = 1'($urandom % 2);
        end
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_outs("idle", mk(0, 0, 0, '0, 1, 0, 0, 0, 0, 0));
            load_valid = 1'($urandom % 2);
            load_data  = $urandom;
            load_last  = 1'($urandom % 2);
        end
        load_valid = 1'b0;

        for (int s = 0; s < 8; s++) begin
            build_image(tbl[s].n, tbl[s].fixed_image);
            do_load(tbl[s].n, tbl[s].gap, tbl[s].req_in_clear, -1);
            check_int($sformatf("scen%0d_word_count", s), int'(word_count), tbl[s].exp_wc);
            check_int($sformatf("scen%0d_overflow", s), int'(overflow), int'(tbl[s].exp_ovf));
        end

        // Reset pulsed mid-load after two words, then a fresh load from IDLE.
        build_image(5, 1'b1);
        do_load(5, 0, 1'b0, 2);
        build_image(3, 1'b1);
        do_load(3, 0, 1'b0, -1);
        check_int("fresh_word_count", int'(word_count), 3);
        check_int("fresh_done", int'(done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, instruction/data word width; ADDRESS_BITS, 32, core address width; MEM_ADDRESS_BITS, 10, word-address width of program BRAM; BOOT_ADDRESS, 0, value driven on program_address at start.
REQ-002 The module SHALL have a single clock domain; the clock is `clock`; reset is `reset`, asynchronous and active-low.
REQ-003 Ports SHALL be, in order:
  clock  in  1  system clock
  reset  in  1  asynchronous, active-low reset
  load_request  in  1  one-cycle pulse, begin a program load
  load_valid  in  1  load_data word offered
  load_data  in  DATA_WIDTH  program word
  load_last  in  1  qualifies final word of image
  load_ready  out  1  loader accepts word this cycle
  mem_write  out  1  BRAM write strobe
  mem_address  out  MEM_ADDRESS_BITS  BRAM word address
  mem_data  out  DATA_WIDTH  BRAM write data
  mem_byte_en  out  DATA_WIDTH/8  per-byte write enable
  core_reset  out  1  active-high hold of core reset
  start  out  1  one-cycle core start pulse
  program_address  out  ADDRESS_BITS  core boot address
  busy  out  1  load sequence in progress
  done  out  1  image loaded, core released
  overflow  out  1  image exceeded memory capacity
  word_count  out  MEM_ADDRESS_BITS+1  words written in last load

Function
REQ-004 States SHALL be IDLE, CLEAR, LOAD, DRAIN, START, RUN.
REQ-005 IDLE: core_reset=1, load_ready=0; load_request -> CLEAR, clears done, overflow, word_count.
REQ-006 CLEAR: one zero-word write per cycle, addresses 0..2^MEM_ADDRESS_BITS-1 ascending, mem_byte_en all ones, mem_data 0; after address 2^MEM_ADDRESS_BITS-1 -> LOAD; takes exactly 2^MEM_ADDRESS_BITS cycles.
REQ-007 LOAD: load_ready=1; word accepted when load_valid && load_ready.
REQ-008 Accepted word SHALL appear on mem_write/mem_address/mem_data exactly one cycle after acceptance (registered), at address = word_count before increment, mem_byte_en all ones.
REQ-009 Word addresses SHALL start at 0 and increment by 1 per accepted word, without gaps; load_valid low stalls with no write.
REQ-010 Words accepted when word_count == 2^MEM_ADDRESS_BITS SHALL be consumed (load_ready stays 1) but not written; overflow SHALL set and hold until next load_request; word_count saturates.
REQ-011 Accepted word with load_last=1 -> DRAIN; load_ready=0 from the following cycle.
REQ-012 DRAIN: one cycle, completes final write; -> START.
REQ-013 START: one cycle; core_reset=0, start=1, program_address=BOOT_ADDRESS; -> RUN.
REQ-014 RUN: core_reset=0, start=0, done=1, busy=0; program_address holds BOOT_ADDRESS.
REQ-015 busy SHALL be 1 in CLEAR, LOAD, DRAIN, START; 0 otherwise.
REQ-016 load_request in RUN SHALL restart: core_reset=1 next cycle, done=0, -> CLEAR.
REQ-017 load_request in CLEAR, LOAD, DRAIN, START SHALL be ignored.
REQ-018 load_valid outside LOAD SHALL be ignored (load_ready=0, no write).
REQ-019 mem_write SHALL be 0 in every cycle not defined by REQ-006/REQ-008.

Reset
REQ-020 While reset=0: state IDLE, load_ready=0, mem_write=0, mem_address=0, mem_data=0, mem_byte_en=0, core_reset=1, start=0, program_address=BOOT_ADDRESS, busy=0, done=0, overflow=0, word_count=0.
REQ-021 Reset asserted mid-operation SHALL abort immediately to REQ-020 values; pending write dropped; no start pulse.
REQ-022 After reset release, block SHALL remain in IDLE until load_request.

Verification (MEM_ADDRESS_BITS=4, BOOT_ADDRESS=0)
REQ-023 load_request, 3 words 0x00000093, 0x00100113, 0x002081B3 (last on 3rd), valid every cycle -> 16 zero writes, then writes addr 0,1,2 one cycle after each accept, DRAIN, one-cycle start with core_reset falling same cycle, done=1, word_count=3.
REQ-024 Same image with load_valid toggled every other cycle -> identical write sequence, no gaps in addresses, no writes on idle cycles.
REQ-025 17 words, last on 17th -> 16 writes, 17th not written, overflow=1, word_count=16, core still started.
REQ-026 Reset pulsed low during LOAD after 2 words -> all outputs at REQ-020 values, start never pulses; fresh load succeeds.
REQ-027 load_request in RUN -> core_reset=1 next cycle, done=0, full CLEAR repeated; load_request during CLEAR has no effect.
REQ-028 Single word with load_last=1 -> one write to address 0, start pulses exactly once, word_count=1.
